// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, counter width and byte-merge helper for dmem_responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Wide enough for the largest legal latency of 15
    localparam int CNT_W = 4;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the MEM stage and dmem_responder
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wmask_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, wmask_i,
        input  rdata_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, wmask_i,
        output rdata_o, ack_o, err_o, stall_o
    );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-masked write and registered read, active only on commit
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           i_we,
    input  logic                           i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [31:0]                    i_wdata,
    input  logic [3:0]                     i_wmask,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Reset gates the write so an access aborted on its commit edge leaves memory untouched
    always_ff @(posedge clk_i) begin
        if (i_we && !rst_i) begin
            r_mem[i_idx] <= merge_bytes(r_mem[i_idx], i_wdata, i_wmask);
        end
    end

    // Read register holds data only for the cycle after a load commit, zero otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= 32'd0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end else begin
            r_rdata <= 32'd0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with pipeline stall; DMEM_ERR_CHECK_EN enables fault checks
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wmask;
    logic             r_ack;
    logic             r_err;

    logic             w_idle;
    logic             w_we;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [3:0]       w_wmask;
    logic             w_commit;
    logic             w_fault;
    logic [AW-1:0]    w_idx;
    logic [31:0]      w_rdata;

    // With LATENCY=1 the commit edge is also the acceptance edge, so the live bus fields are used
    assign w_idle  = (r_state == IDLE);
    assign w_we    = w_idle ? bus.we_i    : r_we;
    assign w_addr  = w_idle ? bus.addr_i  : r_addr;
    assign w_wdata = w_idle ? bus.wdata_i : r_wdata;
    assign w_wmask = w_idle ? bus.wmask_i : r_wmask;
    assign w_idx   = w_addr[AW+1:2];

    assign w_commit = (w_idle && bus.req_i && (LATENCY == 1)) ||
                      ((r_state == WAIT) && (r_cnt <= CNT_W'(1)));

`ifdef DMEM_ERR_CHECK_EN
    assign w_fault = (w_addr[1:0] != 2'b00) ||
                     ({1'b0, w_addr} >= (33'(DEPTH_WORDS) * 33'd4));
`else
    logic w_unused_addr;
    assign w_fault       = 1'b0;
    assign w_unused_addr = ^{w_addr[31:AW+2], w_addr[1:0]};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wmask <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_i) begin
                        r_we    <= bus.we_i;
                        r_addr  <= bus.addr_i;
                        r_wdata <= bus.wdata_i;
                        r_wmask <= bus.wmask_i;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_ack   <= 1'b1;
                            r_err   <= w_fault;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Leaving on the edge where the count reaches 0 puts the ack in cycle LATENCY
                    if (r_cnt <= CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= RESP;
                        r_ack   <= 1'b1;
                        r_err   <= w_fault;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_we    (w_commit &  w_we & ~w_fault),
        .i_re    (w_commit & ~w_we & ~w_fault),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .i_wmask (w_wmask),
        .o_rdata (w_rdata)
    );

    assign bus.rdata_o = w_rdata;
    assign bus.ack_o   = r_ack;
    assign bus.err_o   = r_err;
    assign bus.stall_o = bus.req_i & ~r_ack;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (LATENCY 3 and LATENCY 1 instances)
module tb_dmem_responder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    dmem_responder_if bus3 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one access on the LATENCY=3 instance; entered just after a rising edge
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, output logic [31:0] rd, output logic er,
                             output int ack_cyc, output int stall_cnt);
        bus3.req_i   = 1'b1;
        bus3.we_i    = we;
        bus3.addr_i  = addr;
        bus3.wdata_i = wdata;
        bus3.wmask_i = mask;
        ack_cyc   = -1;
        stall_cnt = 0;
        rd        = 32'hx;
        er        = 1'bx;
        for (int k = 0; k < 20 && ack_cyc < 0; k++) begin
            @(negedge clk);
            if (bus3.stall_o) stall_cnt++;
            if (bus3.ack_o) begin
                ack_cyc = k;
                rd      = bus3.rdata_o;
                er      = bus3.err_o;
            end
            @(posedge clk);
            #1;
        end
        bus3.req_i   = 1'b0;
        bus3.we_i    = 1'b0;
        bus3.addr_i  = 32'd0;
        bus3.wdata_i = 32'd0;
        bus3.wmask_i = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (bus3.ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", bus3.ack_o); end
        n_cmp++; if (bus3.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", bus3.err_o); end
        n_cmp++; if (bus3.rdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", bus3.rdata_o); end
        n_cmp++; if (bus3.stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", bus3.stall_o); end
        n_cmp++; if (bus1.ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack_l1: got %b expected 0", bus1.ack_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          ac;
        int          sc;
        do_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, ac, sc);
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL store_ack_cycle: got %0d expected 3", ac); end
        n_cmp++; if (sc !== 3) begin n_bad++; $display("FAIL store_stall_cycles: got %0d expected 3", sc); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL store_err: got %b expected 0", er); end
        do_access(1'b0, 32'h10, 32'd0, 4'h0, rd, er, ac, sc);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL load_ack_cycle: got %0d expected 3", ac); end
        n_cmp++; if (sc !== 3) begin n_bad++; $display("FAIL load_stall_cycles: got %0d expected 3", sc); end
        @(negedge clk);
        n_cmp++; if (bus3.rdata_o !== 32'd0) begin n_bad++; $display("FAIL rdata_after_ack: got %h expected 0", bus3.rdata_o); end
        n_cmp++; if (bus3.ack_o !== 1'b0) begin n_bad++; $display("FAIL ack_single_pulse: got %b expected 0", bus3.ack_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd;
        logic        er;
        int          ac;
        int          sc;
        do_access(1'b1, 32'h14, 32'h11223344, 4'hF, rd, er, ac, sc);
        do_access(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, rd, er, ac, sc);
        do_access(1'b0, 32'h14, 32'd0, 4'h0, rd, er, ac, sc);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL byte_mask: got %h expected 11bb33dd", rd); end
        do_access(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, rd, er, ac, sc);
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL mask0_ack_cycle: got %0d expected 3", ac); end
        do_access(1'b0, 32'h14, 32'd0, 4'h0, rd, er, ac, sc);
        n_cmp++; if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL mask0_unchanged: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_back_to_back();
        logic exp_ack [6];
        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus1.req_i   = 1'b1;
        bus1.we_i    = 1'b1;
        bus1.addr_i  = 32'h8;
        bus1.wdata_i = 32'h12345678;
        bus1.wmask_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++; if (bus1.ack_o !== exp_ack[k]) begin n_bad++; $display("FAIL b2b_ack_cycle%0d: got %b expected %b", k, bus1.ack_o, exp_ack[k]); end
            n_cmp++; if (bus1.stall_o !== !exp_ack[k]) begin n_bad++; $display("FAIL b2b_stall_cycle%0d: got %b expected %b", k, bus1.stall_o, !exp_ack[k]); end
            @(posedge clk);
            #1;
        end
        bus1.req_i = 1'b0;
        bus1.we_i  = 1'b0;
        @(posedge clk);
        #1;
        bus1.req_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus1.ack_o !== 1'b0) begin n_bad++; $display("FAIL l1_load_cycle0: got %b expected 0", bus1.ack_o); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (bus1.rdata_o !== 32'h12345678) begin n_bad++; $display("FAIL l1_load_rdata: got %h expected 12345678", bus1.rdata_o); end
        @(posedge clk);
        #1;
        bus1.req_i  = 1'b0;
        bus1.addr_i = 32'd0;
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic        er;
        int          ac;
        int          sc;
`ifdef DMEM_ERR_CHECK_EN
        do_access(1'b0, 32'h13, 32'd0, 4'h0, rd, er, ac, sc);
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL misalign_ack_cycle: got %0d expected 3", ac); end
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL misalign_err: got %b expected 1", er); end
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL misalign_rdata: got %h expected 0", rd); end
        do_access(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, ac, sc);
        do_access(1'b1, 32'h400, 32'h0BADC0DE, 4'hF, rd, er, ac, sc);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL range_err: got %b expected 1", er); end
        do_access(1'b0, 32'h0, 32'd0, 4'h0, rd, er, ac, sc);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL range_no_write: got %h expected cafef00d", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL range_good_err: got %b expected 0", er); end
`else
        do_access(1'b0, 32'h13, 32'd0, 4'h0, rd, er, ac, sc);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lowbits_err: got %b expected 0", er); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lowbits_rdata: got %h expected deadbeef", rd); end
        do_access(1'b1, 32'h400, 32'h0BADC0DE, 4'hF, rd, er, ac, sc);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %b expected 0", er); end
        do_access(1'b0, 32'h0, 32'd0, 4'h0, rd, er, ac, sc);
        n_cmp++; if (rd !== 32'h0BADC0DE) begin n_bad++; $display("FAIL wrap_rdata: got %h expected 0badc0de", rd); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          ac;
        int          sc;
        int          acks;
        do_access(1'b1, 32'h20, 32'h55AA55AA, 4'hF, rd, er, ac, sc);
        bus3.req_i   = 1'b1;
        bus3.we_i    = 1'b1;
        bus3.addr_i  = 32'h20;
        bus3.wdata_i = 32'hFFFFFFFF;
        bus3.wmask_i = 4'hF;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst        = 1'b1;
        bus3.req_i = 1'b0;
        bus3.we_i  = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus3.ack_o) acks++;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL reset_mid_ack: got %0d acks expected 0", acks); end
        do_access(1'b0, 32'h20, 32'd0, 4'h0, rd, er, ac, sc);
        n_cmp++; if (rd !== 32'h55AA55AA) begin n_bad++; $display("FAIL reset_mid_data: got %h expected 55aa55aa", rd); end
        n_cmp++; if (ac !== 3) begin n_bad++; $display("FAIL reset_mid_recover: got %0d expected 3", ac); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus3.req_i = 1'b0; bus3.we_i = 1'b0; bus3.addr_i = 32'd0; bus3.wdata_i = 32'd0; bus3.wmask_i = 4'd0;
        bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = 32'd0; bus1.wdata_i = 32'd0; bus1.wmask_i = 4'd0;
        test_reset();
        test_store_load();
        test_byte_mask();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder sitting on the MEM-stage side of the pipelined CPU, answering the load/store requests that the EX/MEM pipeline register presents. It accepts one request at a time, models a fixed access latency with a counter-driven FSM, and returns read data with a one-cycle acknowledge. While an access is in flight it drives a stall back to the pipeline, so the core freezes PC, IF/ID, ID/EX and EX/MEM until completion.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two.
- `LATENCY`, default 3: cycles from acceptance to `ack_o`; legal range 1..15.
- `clk_i` input, 1 bit: single clock; all state is updated on the rising edge.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `req_i` input, 1 bit: access request; held with its fields stable until `ack_o`.
- `we_i` input, 1 bit: 1 = store, 0 = load.
- `addr_i` input, 32 bits: byte address; `EXMEM` ALU result.
- `wdata_i` input, 32 bits: store data; `EXMEM` RS2 data.
- `wmask_i` input, 4 bits: byte-enable for stores; bit n enables `wdata_i[8n+7:8n]`.
- `rdata_o` output, 32 bits: load data; valid only while `ack_o`=1, otherwise 0.
- `ack_o` output, 1 bit: one-cycle completion pulse.
- `err_o` output, 1 bit: access faulted; valid with `ack_o`.
- `stall_o` output, 1 bit: combinational `req_i & ~ack_o`; freezes upstream pipeline registers.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on `req_i`=1, latch `we_i`/`addr_i`/`wdata_i`/`wmask_i`, load the counter with `LATENCY-1`, and go to WAIT. If `LATENCY`=1, go directly to RESP.
- WAIT: decrement the counter each cycle. At 0, go to RESP. This is the commit edge: stores write the array, and loads register the array word into `rdata_o`.
- RESP: `ack_o`=1 for exactly one cycle, then go to IDLE. A new request can be accepted in the first IDLE cycle after the ack, never in the ack cycle itself.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
- Store with `wmask_i`=0: no bytes change; still acknowledged.
- `req_i` dropping before `ack_o` is a protocol violation. The block completes the latched access regardless.
- Array contents are not initialised by reset.

## Timing
- Reset values: state IDLE, counter 0, `ack_o`=0, `err_o`=0, `rdata_o`=0, latched fields 0. `stall_o` follows `req_i` (ack is 0).
- Latency: `req_i` rises in cycle 0 while IDLE, and `ack_o`=1 in cycle `LATENCY`. Back-to-back requests complete every `LATENCY+1` cycles.
- `stall_o` is high in cycles 0..`LATENCY-1` and low in the ack cycle, so the pipeline advances on the edge ending the ack cycle.
- Reset during WAIT aborts the access: no array write, no ack. Reset on the commit edge: reset wins and the write is suppressed.
- Read-after-write to the same word on consecutive requests returns the new data, because the write commits before the next acceptance.

## Configuration
- `DMEM_ERR_CHECK_EN` defined: a request faults if `addr[1:0]`≠0 or `addr_i` ≥ `DEPTH_WORDS*4`. A faulting access runs the same latency and asserts `ack_o`=1 with `err_o`=1 and `rdata_o`=0, and performs no write.
- `DMEM_ERR_CHECK_EN` undefined:
  - `addr[1:0]` is ignored.
  - The address wraps modulo `DEPTH_WORDS*4`.
  - `err_o` is tied to 0.
  - No check logic is synthesised.

## Structure
- Shared package `dmem_pkg`: state enum (IDLE/WAIT/RESP), the `LATENCY` counter width constant, and the byte-mask-merge function used by the array.
- Sub-module `dmem_array`: `DEPTH_WORDS`×32 storage with byte-masked synchronous write and registered read, enabled only on the commit edge.
- FSM, counter, request latches, error check and `stall_o` live in `dmem_responder`.

## Test plan
- Reset then idle: `rst_i`=1 for 2 cycles → all outputs 0; `stall_o`=0 with `req_i`=0.
- Store then load: store `addr`=0x10, data 0xDEADBEEF, mask 0xF; then load `addr`=0x10 → `rdata_o`=0xDEADBEEF. Each `ack_o` pulse appears exactly 3 cycles after acceptance, with `stall_o` high for 3 cycles per access.
- Byte mask: memory word 0x11223344, store 0xAABBCCDD with mask 0b0101 → subsequent load returns 0x11BB33DD.
- Latency 1 back-to-back: with `LATENCY`=1 and `req_i` held high → acks on cycles 1, 3, 5.
- Error path (macro defined): load `addr`=0x13 → `ack_o`=1, `err_o`=1, `rdata_o`=0. A store to 0x400 with depth 256 → `err_o`=1 and memory unchanged.
- Reset mid-access: store to 0x20 issued, `rst_i` pulsed in cycle 2 → no ack. A later load of 0x20 returns the prior value.
